lives_manager: RTL and testbench
================================

# lives_manager

Parametrised multi-player lives tracker for the Bomber Man game core. It holds a saturating life counter per player, fed by rising edges on per-player hit and bonus event lines. After each non-fatal hit, a post-hit invulnerability window ignores further hits. It reports per-player death, a one-cycle death pulse, and a global game-over flag to the game-state controller and HUD bitmap logic.

## Interface
- NUM_PLAYERS, 2, number of independent player channels (≥1)
- MAX_LIVES, 7, saturation ceiling of each counter (≥1)
- INIT_LIVES, 3, value loaded on reset/restart; 1 ≤ INIT_LIVES ≤ MAX_LIVES
- INVULN_CYCLES, 100, length of post-hit invulnerability in clk cycles (≥1)
- LIVES_W (localparam), $clog2(MAX_LIVES+1), counter width
- clk  in  1  system clock
- resetN  in  1  reset resetN, asynchronous, active-low; clock clk
- restart  in  1  synchronous new-game request, level-sampled
- hit  in  NUM_PLAYERS  per-player damage event, rising-edge detected
- bonus  in  NUM_PLAYERS  per-player extra-life event, rising-edge detected
- lives  out  NUM_PLAYERS*LIVES_W  packed counters; player i at [i*LIVES_W +: LIVES_W]
- invuln  out  NUM_PLAYERS  high while player is in INVULN
- dead  out  NUM_PLAYERS  high while player is in DEAD
- died_pulse  out  NUM_PLAYERS  one-cycle pulse on the ALIVE→DEAD transition
- game_over  out  1  high while all players are DEAD

## Operation
- Each channel runs a 3-state FSM: ALIVE, INVULN, DEAD. It has a registered previous copy of hit/bonus for edge detection.
- hit_edge = hit & ~hit_prev; bonus_edge = bonus & ~bonus_prev. Prev registers update every cycle.
- ALIVE + hit_edge: lives−1. If the result is 0, go to DEAD and assert died_pulse. Otherwise go to INVULN and load the timer with INVULN_CYCLES.
- INVULN: hit_edge ignored. Timer decrements each cycle. When timer==1, go to ALIVE, so invuln is high for exactly INVULN_CYCLES cycles.
- bonus_edge in ALIVE or INVULN: lives+1, saturating at MAX_LIVES. It does not change state or timer.
- DEAD: hit_edge and bonus_edge are ignored, and lives stays 0. Only restart or reset leaves DEAD.
- Simultaneous hit_edge and bonus_edge in ALIVE: net lives unchanged (at MAX_LIVES result stays MAX_LIVES). State goes to INVULN and death is never taken.
- Simultaneous hit_edge and bonus_edge in INVULN: bonus only.
- restart has priority over all events. On restart, all channels get lives=INIT_LIVES, ALIVE, timer 0, and prev registers capture current inputs, so held lines do not fire.
- game_over = &dead, registered from next-state, so it rises in the same cycle as the last dead bit.
- Counter arithmetic is unsigned LIVES_W bits, with no wrap in either direction.

## Timing
- Reset values: lives=INIT_LIVES for every player; invuln, dead, died_pulse and game_over are 0; FSM is ALIVE; timers and prev registers are 0.
- Events are acted on at the first clk edge where the input is 1 and prev is 0. Outputs reflect the result from the following cycle, giving 1-cycle latency.
- A held input produces exactly one event. It must drop for ≥1 cycle before re-firing.
- An asynchronous reset mid-INVULN or mid-pulse aborts immediately to reset values.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- LIVES_INVULN_EN defined: INVULN state, timer and invuln output are implemented as above.
- LIVES_INVULN_EN undefined: no timer or INVULN state. A non-fatal hit stays ALIVE, and every hit_edge decrements. invuln is tied 0 and INVULN_CYCLES is unused.

## Structure
- Package lives_pkg: typedef enum logic [1:0] player_state_t {ALIVE, INVULN, DEAD}, plus a parameter-check function for INIT_LIVES vs MAX_LIVES.
- Sub-module lives_channel holds one player's FSM, counter, timer and edge detectors, and is instantiated NUM_PLAYERS times via generate.
- The top level handles restart fan-out, lives packing and the game_over reduction.

## Test plan
Bench parameters for all scenarios: NUM_PLAYERS=2, MAX_LIVES=7, INIT_LIVES=3, INVULN_CYCLES=4, macro defined.
- Reset, then one hit pulse on P0: lives0 3→2 one cycle later; invuln0 high for exactly 4 cycles; P1 unchanged at 3.
- Second P0 hit edge 2 cycles into INVULN: ignored, lives0 stays 2. A hit after invuln0 falls gives lives0=1.
- Hit P0 at lives=1: lives0=0, dead0=1, died_pulse0 high for exactly 1 cycle, game_over=0. Later hit/bonus on P0 is ignored.
- Six bonus edges on P1 from 3: lives1 reaches 7 and stays 7. A hit held high for 20 cycles decrements once, to 6.
- Same-cycle hit and bonus on P1 at lives=1: lives1 stays 1 and invuln1=1. Kill both players: game_over=1 in the same cycle as the final dead bit.
- restart asserted while hit is held high and P0 is mid-INVULN: both lives=3, ALIVE, game_over=0, and no hit event on the following cycle.

Source files
------------

// File: rtl/lives_pkg.sv
// lives_pkg
//   Shared types and helpers for the lives_manager block.
//   - player_state_t : per-player FSM state (ALIVE / INVULN / DEAD)
//   - lives_params_ok: elaboration-time sanity check of the block parameters
//   Optional feature macro used by the block: LIVES_INVULN_EN
package lives_pkg;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } player_state_t;

   function automatic bit lives_params_ok(input int unsigned num_players,
                                          input int unsigned max_lives,
                                          input int unsigned init_lives,
                                          input int unsigned invuln_cycles);
      return (num_players >= 1) && (max_lives >= 1) && (init_lives >= 1) &&
             (init_lives <= max_lives) && (invuln_cycles >= 1);
   endfunction

endpackage

// File: rtl/lives_channel.sv
// lives_channel
//   One player's lives tracker: edge detectors on hit/bonus, saturating life
//   counter, ALIVE/INVULN/DEAD FSM and (optionally) the invulnerability timer.
//   Macro LIVES_INVULN_EN enables the INVULN state, timer and invuln output;
//   without it a non-fatal hit stays ALIVE and invuln is tied low.
// Ports
//   clk, resetN  : clock, asynchronous active-low reset
//   restart      : synchronous new-game request (highest priority)
//   hit, bonus   : level inputs, acted on at their rising edge
//   lives        : current life count
//   invuln, dead : state decodes of the registered FSM
//   died_pulse   : one cycle high on the ALIVE->DEAD transition
//   dead_next    : next-state DEAD flag, lets the parent register game_over
//                  in the same cycle as the final dead bit
module lives_channel
   import lives_pkg::*;
#(
   parameter int unsigned MAX_LIVES     = 7,
   parameter int unsigned INIT_LIVES    = 3,
`ifdef LIVES_INVULN_EN
   parameter int unsigned INVULN_CYCLES = 100,
`endif
   localparam int unsigned LIVES_W      = $clog2(MAX_LIVES + 1)
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               restart,
   input  logic               hit,
   input  logic               bonus,
   output logic [LIVES_W-1:0] lives,
   output logic               invuln,
   output logic               dead,
   output logic               died_pulse,
   output logic               dead_next
);

`ifdef LIVES_INVULN_EN
   localparam int unsigned TIMER_W = $clog2(INVULN_CYCLES + 1);
   logic [TIMER_W-1:0] timer_q, timer_d;
`endif

   player_state_t      state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               hit_prev_q, hit_prev_d;
   logic               bonus_prev_q, bonus_prev_d;
   logic               died_pulse_q, died_pulse_d;
   logic               hit_edge, bonus_edge;
   logic [LIVES_W-1:0] lives_inc;

   // State register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ALIVE;
         lives_q      <= LIVES_W'(INIT_LIVES);
         hit_prev_q   <= 1'b0;
         bonus_prev_q <= 1'b0;
         died_pulse_q <= 1'b0;
`ifdef LIVES_INVULN_EN
         timer_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         hit_prev_q   <= hit_prev_d;
         bonus_prev_q <= bonus_prev_d;
         died_pulse_q <= died_pulse_d;
`ifdef LIVES_INVULN_EN
         timer_q      <= timer_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      died_pulse_d = 1'b0;
      // Prev copies track the raw inputs every cycle, including on restart,
      // so a line held through restart does not fire afterwards.
      hit_prev_d   = hit;
      bonus_prev_d = bonus;
`ifdef LIVES_INVULN_EN
      timer_d      = timer_q;
`endif
      hit_edge     = hit & ~hit_prev_q;
      bonus_edge   = bonus & ~bonus_prev_q;
      lives_inc    = (lives_q < LIVES_W'(MAX_LIVES)) ? lives_q + LIVES_W'(1) : lives_q;

      if (restart) begin
         state_d = ALIVE;
         lives_d = LIVES_W'(INIT_LIVES);
`ifdef LIVES_INVULN_EN
         timer_d = '0;
`endif
      end else begin
         unique case (state_q)
            ALIVE: begin
               if (hit_edge && bonus_edge) begin
                  // Hit and bonus cancel; the hit still counts as non-fatal.
`ifdef LIVES_INVULN_EN
                  state_d = INVULN;
                  timer_d = TIMER_W'(INVULN_CYCLES);
`endif
               end else if (hit_edge) begin
                  if (lives_q <= LIVES_W'(1)) begin
                     lives_d      = '0;
                     state_d      = DEAD;
                     died_pulse_d = 1'b1;
                  end else begin
                     lives_d = lives_q - LIVES_W'(1);
`ifdef LIVES_INVULN_EN
                     state_d = INVULN;
                     timer_d = TIMER_W'(INVULN_CYCLES);
`endif
                  end
               end else if (bonus_edge) begin
                  lives_d = lives_inc;
               end
            end
`ifdef LIVES_INVULN_EN
            INVULN: begin
               if (bonus_edge) begin
                  lives_d = lives_inc;
               end
               timer_d = timer_q - TIMER_W'(1);
               if (timer_q == TIMER_W'(1)) begin
                  state_d = ALIVE;
               end
            end
`endif
            DEAD: begin
               lives_d = '0;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   // Output decode
   always_comb begin
      lives      = lives_q;
      dead       = (state_q == DEAD);
      died_pulse = died_pulse_q;
      dead_next  = (state_d == DEAD);
`ifdef LIVES_INVULN_EN
      invuln     = (state_q == INVULN);
`else
      invuln     = 1'b0;
`endif
   end

endmodule

// File: rtl/lives_manager.sv
// lives_manager
//   Multi-player lives tracker for the Bomber Man game core. One lives_channel
//   per player; this level fans out restart, packs the counters and forms the
//   registered game_over flag.
//   Macro LIVES_INVULN_EN enables the post-hit invulnerability window.
// Ports
//   clk, resetN  : clock, asynchronous active-low reset
//   restart      : synchronous new-game request
//   hit, bonus   : per-player event lines (rising-edge detected)
//   lives        : packed counters, player i at [i*LIVES_W +: LIVES_W]
//   invuln       : per-player invulnerability flag
//   dead         : per-player dead flag
//   died_pulse   : per-player one-cycle death pulse
//   game_over    : high while every player is dead
module lives_manager
   import lives_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS   = 2,
   parameter int unsigned MAX_LIVES     = 7,
   parameter int unsigned INIT_LIVES    = 3,
   parameter int unsigned INVULN_CYCLES = 100,
   localparam int unsigned LIVES_W      = $clog2(MAX_LIVES + 1)
) (
   input  logic                           clk,
   input  logic                           resetN,
   input  logic                           restart,
   input  logic [NUM_PLAYERS-1:0]         hit,
   input  logic [NUM_PLAYERS-1:0]         bonus,
   output logic [NUM_PLAYERS*LIVES_W-1:0] lives,
   output logic [NUM_PLAYERS-1:0]         invuln,
   output logic [NUM_PLAYERS-1:0]         dead,
   output logic [NUM_PLAYERS-1:0]         died_pulse,
   output logic                           game_over
);

   if (!lives_params_ok(NUM_PLAYERS, MAX_LIVES, INIT_LIVES, INVULN_CYCLES)) begin : g_param_error
      $error("lives_manager: illegal parameter combination");
   end

   logic [NUM_PLAYERS-1:0] dead_next;
   logic                   game_over_q, game_over_d;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
      lives_channel #(
         .MAX_LIVES     (MAX_LIVES),
`ifdef LIVES_INVULN_EN
         .INVULN_CYCLES (INVULN_CYCLES),
`endif
         .INIT_LIVES    (INIT_LIVES)
      ) u_channel (
         .clk        (clk),
         .resetN     (resetN),
         .restart    (restart),
         .hit        (hit[i]),
         .bonus      (bonus[i]),
         .lives      (lives[i*LIVES_W +: LIVES_W]),
         .invuln     (invuln[i]),
         .dead       (dead[i]),
         .died_pulse (died_pulse[i]),
         .dead_next  (dead_next[i])
      );
   end

   // Built from next-state so it rises together with the last dead bit.
   always_comb begin
      game_over_d = &dead_next;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         game_over_q <= 1'b0;
      end else begin
         game_over_q <= game_over_d;
      end
   end

   always_comb begin
      game_over = game_over_q;
   end

endmodule

// File: tb/tb_lives_manager.sv
// tb_lives_manager
//   Self-checking bench for lives_manager (2 players, MAX 7, INIT 3, window 4).
//   Directed vector table plus hand sequences, then randomized traffic checked
//   every cycle against a behavioural model. Expectations follow whether
//   LIVES_INVULN_EN is defined for the build.
module tb_lives_manager;

   localparam int NP    = 2;
   localparam int MAXL  = 7;
   localparam int INITL = 3;
   localparam int INVC  = 4;
   localparam int LW    = 3;
`ifdef LIVES_INVULN_EN
   localparam bit E = 1'b1;
`else
   localparam bit E = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              resetN;
   logic              restart;
   logic [NP-1:0]     hit, bonus;
   logic [NP*LW-1:0]  lives;
   logic [NP-1:0]     invuln, dead, died_pulse;
   logic              game_over;

   int checks   = 0;
   int failures = 0;

   lives_manager #(
      .NUM_PLAYERS   (NP),
      .MAX_LIVES     (MAXL),
      .INIT_LIVES    (INITL),
      .INVULN_CYCLES (INVC)
   ) dut (
      .clk        (clk),
      .resetN     (resetN),
      .restart    (restart),
      .hit        (hit),
      .bonus      (bonus),
      .lives      (lives),
      .invuln     (invuln),
      .dead       (dead),
      .died_pulse (died_pulse),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_lives [NP];
   int m_inv   [NP];   // remaining invulnerable cycles
   bit m_dead  [NP];
   bit m_pulse [NP];
   bit m_hp    [NP];
   bit m_bp    [NP];

   function automatic void model_reset();
      for (int p = 0; p < NP; p++) begin
         m_lives[p] = INITL;
         m_inv[p]   = 0;
         m_dead[p]  = 1'b0;
         m_pulse[p] = 1'b0;
         m_hp[p]    = 1'b0;
         m_bp[p]    = 1'b0;
      end
   endfunction

   function automatic void model_step(input bit r, input logic [NP-1:0] h, input logic [NP-1:0] b);
      for (int p = 0; p < NP; p++) begin
         bit he;
         bit be;
         he = h[p] & ~m_hp[p];
         be = b[p] & ~m_bp[p];
         m_hp[p]    = h[p];
         m_bp[p]    = b[p];
         m_pulse[p] = 1'b0;
         if (r) begin
            m_lives[p] = INITL;
            m_inv[p]   = 0;
            m_dead[p]  = 1'b0;
         end else if (!m_dead[p]) begin
            if (m_inv[p] > 0) begin
               m_inv[p] = m_inv[p] - 1;
               if (be) m_lives[p] = (m_lives[p] + 1 > MAXL) ? MAXL : m_lives[p] + 1;
            end else if (he) begin
               if (!be) m_lives[p] = m_lives[p] - 1;
               if (m_lives[p] == 0) begin
                  m_dead[p]  = 1'b1;
                  m_pulse[p] = 1'b1;
               end else if (E) begin
                  m_inv[p] = INVC;
               end
            end else if (be) begin
               m_lives[p] = (m_lives[p] + 1 > MAXL) ? MAXL : m_lives[p] + 1;
            end
         end
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [NP*LW-1:0] el;
      logic [NP-1:0]    ei, ed, ep;
      logic             eg;
      eg = 1'b1;
      for (int p = 0; p < NP; p++) begin
         el[p*LW +: LW] = LW'(m_lives[p]);
         ei[p] = (m_inv[p] > 0);
         ed[p] = m_dead[p];
         ep[p] = m_pulse[p];
         eg    = eg & m_dead[p];
      end
      chk("model_lives",  32'(lives),      32'(el));
      chk("model_invuln", 32'(invuln),     32'(ei));
      chk("model_dead",   32'(dead),       32'(ed));
      chk("model_pulse",  32'(died_pulse), 32'(ep));
      chk("model_go",     32'(game_over),  32'(eg));
   endtask

   task automatic step(input logic r, input logic [NP-1:0] h, input logic [NP-1:0] b);
      @(negedge clk);
      restart = r;
      hit     = h;
      bonus   = b;
      @(posedge clk);
      model_step(r, h, b);
      #1;
      check_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0] hit;
      logic [1:0] bonus;
      int         l0;
      int         l1;
      logic [1:0] inv;
      logic [1:0] dd;
      logic [1:0] pl;
      logic       go;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [1:0] h, input logic [1:0] b, input int l0, input int l1,
                               input logic [1:0] inv, input logic [1:0] dd, input logic [1:0] pl,
                               input logic go);
      vec_t v;
      v.hit = h; v.bonus = b; v.l0 = l0; v.l1 = l1;
      v.inv = inv; v.dd = dd; v.pl = pl; v.go = go;
      vecs.push_back(v);
   endfunction

   initial begin
      int inv_cnt;
      resetN  = 1'b0;
      restart = 1'b0;
      hit     = '0;
      bonus   = '0;
      model_reset();

      // P0: hit, ignored hit inside the window, hit after it, fatal hit, then ignored events.
      add(2'b01, 2'b00, 2,        3, E ? 2'b01 : 2'b00, 2'b00,              2'b00,              1'b0);
      add(2'b00, 2'b00, 2,        3, E ? 2'b01 : 2'b00, 2'b00,              2'b00,              1'b0);
      add(2'b01, 2'b00, E ? 2 : 1, 3, E ? 2'b01 : 2'b00, 2'b00,             2'b00,              1'b0);
      add(2'b00, 2'b00, E ? 2 : 1, 3, E ? 2'b01 : 2'b00, 2'b00,             2'b00,              1'b0);
      add(2'b00, 2'b00, E ? 2 : 1, 3, 2'b00,             2'b00,             2'b00,              1'b0);
      add(2'b01, 2'b00, E ? 1 : 0, 3, E ? 2'b01 : 2'b00, E ? 2'b00 : 2'b01, E ? 2'b00 : 2'b01, 1'b0);
      for (int k = 0; k < 3; k++)
         add(2'b00, 2'b00, E ? 1 : 0, 3, E ? 2'b01 : 2'b00, E ? 2'b00 : 2'b01, 2'b00, 1'b0);
      add(2'b00, 2'b00, E ? 1 : 0, 3, 2'b00, E ? 2'b00 : 2'b01, 2'b00,              1'b0);
      add(2'b01, 2'b00, 0,         3, 2'b00, 2'b01,             E ? 2'b01 : 2'b00, 1'b0);
      add(2'b00, 2'b00, 0,         3, 2'b00, 2'b01,             2'b00,              1'b0);
      add(2'b01, 2'b01, 0,         3, 2'b00, 2'b01,             2'b00,              1'b0);
      add(2'b00, 2'b00, 0,         3, 2'b00, 2'b01,             2'b00,              1'b0);
      // P1: six bonus edges from 3, saturating at 7.
      for (int k = 1; k <= 6; k++) begin
         add(2'b00, 2'b10, (3 + k > MAXL) ? MAXL : 3 + k, 0, 2'b00, 2'b01, 2'b00, 1'b0);
         add(2'b00, 2'b00, (3 + k > MAXL) ? MAXL : 3 + k, 0, 2'b00, 2'b01, 2'b00, 1'b0);
      end
      // The P1 bonus rows above carry l1 in the l0 slot; swap them into place.
      for (int i = 14; i < vecs.size(); i++) begin
         vecs[i].l1 = vecs[i].l0;
         vecs[i].l0 = 0;
      end

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("reset_lives",  32'(lives),      32'h1b);
      chk("reset_invuln", 32'(invuln),     0);
      chk("reset_dead",   32'(dead),       0);
      chk("reset_pulse",  32'(died_pulse), 0);
      chk("reset_go",     32'(game_over),  0);
      @(negedge clk);
      resetN = 1'b1;

      foreach (vecs[i]) begin
         step(1'b0, vecs[i].hit, vecs[i].bonus);
         chk($sformatf("vec%0d_lives0", i), 32'(lives[2:0]), 32'(vecs[i].l0));
         chk($sformatf("vec%0d_lives1", i), 32'(lives[5:3]), 32'(vecs[i].l1));
         chk($sformatf("vec%0d_invuln", i), 32'(invuln),     32'(vecs[i].inv));
         chk($sformatf("vec%0d_dead",   i), 32'(dead),       32'(vecs[i].dd));
         chk($sformatf("vec%0d_pulse",  i), 32'(died_pulse), 32'(vecs[i].pl));
         chk($sformatf("vec%0d_go",     i), 32'(game_over),  32'(vecs[i].go));
      end

      // Held hit on P1 for 20 cycles: one decrement only.
      inv_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 2'b10, 2'b00);
         chk("hold_lives1", 32'(lives[5:3]), 6);
         if (invuln[1]) inv_cnt++;
      end
      chk("hold_invuln1_cycles", inv_cnt, E ? INVC : 0);
      step(1'b0, 2'b00, 2'b00);

      // Bring P1 down to 1, then same-cycle hit + bonus.
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 2'b10, 2'b00);
         repeat (INVC + 1) step(1'b0, 2'b00, 2'b00);
      end
      chk("p1_at_one", 32'(lives[5:3]), 1);
      step(1'b0, 2'b10, 2'b10);
      chk("hitbonus_lives1",  32'(lives[5:3]), 1);
      chk("hitbonus_invuln1", 32'(invuln[1]),  32'(E));
      chk("hitbonus_dead1",   32'(dead[1]),    0);
      repeat (INVC + 1) step(1'b0, 2'b00, 2'b00);
      chk("pre_kill_go", 32'(game_over), 0);
      step(1'b0, 2'b10, 2'b00);
      chk("kill_dead",   32'(dead),          3);
      chk("kill_pulse1", 32'(died_pulse[1]), 1);
      chk("kill_go",     32'(game_over),     1);
      step(1'b0, 2'b00, 2'b00);
      chk("post_kill_pulse", 32'(died_pulse), 0);
      chk("post_kill_go",    32'(game_over),  1);

      // Restart while P0 is mid-window with hit held high.
      step(1'b1, 2'b00, 2'b00);
      chk("restart_lives", 32'(lives),     32'h1b);
      chk("restart_go",    32'(game_over), 0);
      step(1'b0, 2'b01, 2'b00);
      chk("rs_hit_lives0",  32'(lives[2:0]), 2);
      chk("rs_hit_invuln0", 32'(invuln[0]),  32'(E));
      step(1'b0, 2'b01, 2'b00);
      chk("rs_held_lives0", 32'(lives[2:0]), 2);
      step(1'b1, 2'b01, 2'b00);
      chk("rs_mid_lives",  32'(lives),     32'h1b);
      chk("rs_mid_invuln", 32'(invuln),    0);
      chk("rs_mid_dead",   32'(dead),      0);
      chk("rs_mid_go",     32'(game_over), 0);
      step(1'b0, 2'b01, 2'b00);
      chk("rs_after_lives0",  32'(lives[2:0]), 3);
      chk("rs_after_invuln0", 32'(invuln[0]),  0);

      // Asynchronous reset in the middle of a window.
      step(1'b0, 2'b00, 2'b00);
      step(1'b0, 2'b01, 2'b00);
      @(negedge clk);
      hit    = '0;
      resetN = 1'b0;
      #1;
      chk("async_lives",  32'(lives),      32'h1b);
      chk("async_invuln", 32'(invuln),     0);
      chk("async_pulse",  32'(died_pulse), 0);
      model_reset();
      @(negedge clk);
      resetN = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         logic          r;
         logic [NP-1:0] h, b;
         r = ($urandom_range(0, 39) == 0);
         for (int p = 0; p < NP; p++) begin
            h[p] = ($urandom_range(0, 3) == 0);
            b[p] = ($urandom_range(0, 4) == 0);
         end
         step(r, h, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
